// File: rtl/dsp19x2_share_arbiter_if.sv
// Bundle between the DSP19X2 share arbiter, its requesters and the DSP19X2 it drives.
//   req_valid/req_ready : per-requester handshake, transfer on valid && ready
//   req_a/req_b         : packed unsigned operands, requester i at [10i+9:10i] / [9i+8:9i]
//   dsp_a1/b1/a2/b2     : operands to the two fractured 10x9 multiply lanes
//   dsp_z1/dsp_z2       : lane products returned by the DSP
//   rspN_valid/id/z     : per-lane registered result tagged with the requester id
// slave is the arbiter side; master is the requester/DSP side.
interface dsp19x2_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*10-1:0] req_a;
  logic [NREQ*9-1:0]  req_b;
  logic [9:0]         dsp_a1;
  logic [8:0]         dsp_b1;
  logic [9:0]         dsp_a2;
  logic [8:0]         dsp_b2;
  logic [18:0]        dsp_z1;
  logic [18:0]        dsp_z2;
  logic               rsp1_valid;
  logic [IDW-1:0]     rsp1_id;
  logic [18:0]        rsp1_z;
  logic               rsp2_valid;
  logic [IDW-1:0]     rsp2_id;
  logic [18:0]        rsp2_z;

  modport slave (
    input  req_valid, req_a, req_b, dsp_z1, dsp_z2,
    output req_ready, dsp_a1, dsp_b1, dsp_a2, dsp_b2,
           rsp1_valid, rsp1_id, rsp1_z, rsp2_valid, rsp2_id, rsp2_z
  );

  modport master (
    output req_valid, req_a, req_b, dsp_z1, dsp_z2,
    input  req_ready, dsp_a1, dsp_b1, dsp_a2, dsp_b2,
           rsp1_valid, rsp1_id, rsp1_z, rsp2_valid, rsp2_id, rsp2_z
  );
endinterface

// File: rtl/dsp19x2_share_arbiter.sv
// Shares one DSP19X2 (unsigned multiply, two fractured 10x9 lanes) among NREQ requesters.
// Each cycle up to two valid requesters are granted round-robin from ptr; the first goes to
// lane 1, the second to lane 2. Per-lane (valid, id) tags ride a DSP_LAT-deep shift register
// so they line up with dsp_zN, and are registered together with the product into rspN_*.
// Grant-to-response latency is DSP_LAT+1 cycles.
// Ports:
//   CLK   : clock (same clock feeds the DSP when DSP_LAT > 0)
//   RESET : synchronous active-high reset, dominates everything, also forces req_ready low
//   bus   : request handshake, DSP operand/product wires and tagged responses
module dsp19x2_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DSP_LAT = 0,
  parameter int unsigned IDW     = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dsp19x2_share_arbiter_if.slave bus
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            g1_v, g2_v;
  logic [IDW-1:0]  g1_id, g2_id, last_id;
  logic [NREQ-1:0] ready;
  logic [9:0]      a1, a2;
  logic [8:0]      b1, b2;
  logic [9:0]      a_arr [NREQ];
  logic [8:0]      b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[10*i +: 10];
    assign b_arr[i] = bus.req_b[9*i +: 9];
  end

  // Scan from ptr, wrapping; first valid -> lane 1, second valid -> lane 2.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    sum   = '0;
    idx   = '0;
    g1_v  = 1'b0;
    g2_v  = 1'b0;
    g1_id = '0;
    g2_id = '0;
    ready = '0;
    a1    = '0;
    b1    = '0;
    a2    = '0;
    b2    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (bus.req_valid[idx] && !RESET) begin
        if (!g1_v) begin
          g1_v       = 1'b1;
          g1_id      = idx;
          ready[idx] = 1'b1;
          a1         = a_arr[idx];
          b1         = b_arr[idx];
        end else if (!g2_v) begin
          g2_v       = 1'b1;
          g2_id      = idx;
          ready[idx] = 1'b1;
          a2         = a_arr[idx];
          b2         = b_arr[idx];
        end
      end
    end
  end

  // Pointer moves just past the last grantee, so one requester never takes both lanes.
  always_comb begin
    last_id = g2_v ? g2_id : g1_id;
    if (!g1_v) begin
      ptr_d = ptr_q;
    end else if (last_id == IDW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = last_id + IDW'(1);
    end
  end

  assign bus.req_ready = ready;
  assign bus.dsp_a1    = a1;
  assign bus.dsp_b1    = b1;
  assign bus.dsp_a2    = a2;
  assign bus.dsp_b2    = b2;

  // Tags aligned with dsp_zN.
  logic           al1_v, al2_v;
  logic [IDW-1:0] al1_id, al2_id;

  if (DSP_LAT == 0) begin : g_nolat
    assign al1_v  = g1_v;
    assign al2_v  = g2_v;
    assign al1_id = g1_id;
    assign al2_id = g2_id;
  end else begin : g_lat
    logic [DSP_LAT-1:0]          v1_q, v2_q;
    logic [DSP_LAT-1:0][IDW-1:0] id1_q, id2_q;
    logic [DSP_LAT:0]            v1_chain, v2_chain;
    logic [DSP_LAT:0][IDW-1:0]   id1_chain, id2_chain;

    assign v1_chain  = {v1_q, g1_v};
    assign v2_chain  = {v2_q, g2_v};
    assign id1_chain = {id1_q, g1_id};
    assign id2_chain = {id2_q, g2_id};

    always_ff @(posedge CLK) begin
      if (RESET) begin
        v1_q <= '0;
        v2_q <= '0;
      end else begin
        v1_q <= v1_chain[DSP_LAT-1:0];
        v2_q <= v2_chain[DSP_LAT-1:0];
      end
      id1_q <= id1_chain[DSP_LAT-1:0];
      id2_q <= id2_chain[DSP_LAT-1:0];
    end

    assign al1_v  = v1_chain[DSP_LAT];
    assign al2_v  = v2_chain[DSP_LAT];
    assign al1_id = id1_chain[DSP_LAT];
    assign al2_id = id2_chain[DSP_LAT];
  end

  logic           rsp1_v_q, rsp2_v_q;
  logic [IDW-1:0] rsp1_id_q, rsp2_id_q;
  logic [18:0]    rsp1_z_q, rsp2_z_q;

  // id/z only load on a valid tag so they hold between responses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q     <= '0;
      rsp1_v_q  <= 1'b0;
      rsp1_id_q <= '0;
      rsp1_z_q  <= '0;
      rsp2_v_q  <= 1'b0;
      rsp2_id_q <= '0;
      rsp2_z_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rsp1_v_q <= al1_v;
      rsp2_v_q <= al2_v;
      if (al1_v) begin
        rsp1_id_q <= al1_id;
        rsp1_z_q  <= bus.dsp_z1;
      end
      if (al2_v) begin
        rsp2_id_q <= al2_id;
        rsp2_z_q  <= bus.dsp_z2;
      end
    end
  end

  assign bus.rsp1_valid = rsp1_v_q;
  assign bus.rsp1_id    = rsp1_id_q;
  assign bus.rsp1_z     = rsp1_z_q;
  assign bus.rsp2_valid = rsp2_v_q;
  assign bus.rsp2_id    = rsp2_id_q;
  assign bus.rsp2_z     = rsp2_z_q;

endmodule

// File: tb/tb_dsp19x2_share_arbiter.sv
// Bench for dsp19x2_share_arbiter: three DUTs (DSP_LAT 0, 1, 2) share the same request
// stimulus, each with its own behavioural DSP multiply pipeline. Directed vectors carry
// hand-computed values; a reference arbiter/tag model checks every cycle.
module tb_dsp19x2_share_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned NLAT = 3;

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic [18:0]    z;
  } tag_t;

  logic               clk       = 1'b0;
  logic               rst       = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*10-1:0] req_a     = '0;
  logic [NREQ*9-1:0]  req_b     = '0;

  always #5 clk = ~clk;

  logic [NREQ-1:0] obs_ready [NLAT];
  logic [9:0]      obs_a1 [NLAT];
  logic [8:0]      obs_b1 [NLAT];
  logic [9:0]      obs_a2 [NLAT];
  logic [8:0]      obs_b2 [NLAT];
  logic            obs_r1v [NLAT];
  logic [IDW-1:0]  obs_r1id [NLAT];
  logic [18:0]     obs_r1z [NLAT];
  logic            obs_r2v [NLAT];
  logic [IDW-1:0]  obs_r2id [NLAT];
  logic [18:0]     obs_r2z [NLAT];

  for (genvar l = 0; l < NLAT; l++) begin : g_dut
    dsp19x2_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    assign bus.req_valid = req_valid;
    assign bus.req_a     = req_a;
    assign bus.req_b     = req_b;

    if (l == 0) begin : g_comb
      assign bus.dsp_z1 = {9'd0, bus.dsp_a1} * {10'd0, bus.dsp_b1};
      assign bus.dsp_z2 = {9'd0, bus.dsp_a2} * {10'd0, bus.dsp_b2};
    end else begin : g_reg
      logic [18:0] p1 [l];
      logic [18:0] p2 [l];
      always_ff @(posedge clk) begin
        p1[0] <= {9'd0, bus.dsp_a1} * {10'd0, bus.dsp_b1};
        p2[0] <= {9'd0, bus.dsp_a2} * {10'd0, bus.dsp_b2};
        for (int k = 1; k < l; k++) begin
          p1[k] <= p1[k-1];
          p2[k] <= p2[k-1];
        end
      end
      assign bus.dsp_z1 = p1[l-1];
      assign bus.dsp_z2 = p2[l-1];
    end

    dsp19x2_share_arbiter #(.NREQ(NREQ), .DSP_LAT(l), .IDW(IDW)) u_dut (
      .CLK  (clk),
      .RESET(rst),
      .bus  (bus)
    );

    assign obs_ready[l] = bus.req_ready;
    assign obs_a1[l]    = bus.dsp_a1;
    assign obs_b1[l]    = bus.dsp_b1;
    assign obs_a2[l]    = bus.dsp_a2;
    assign obs_b2[l]    = bus.dsp_b2;
    assign obs_r1v[l]   = bus.rsp1_valid;
    assign obs_r1id[l]  = bus.rsp1_id;
    assign obs_r1z[l]   = bus.rsp1_z;
    assign obs_r2v[l]   = bus.rsp2_valid;
    assign obs_r2id[l]  = bus.rsp2_id;
    assign obs_r2z[l]   = bus.rsp2_z;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned m_ptr   = 0;
  tag_t        pipe1 [NLAT][NLAT];
  tag_t        pipe2 [NLAT][NLAT];
  tag_t        hold1 [NLAT];
  tag_t        hold2 [NLAT];
  bit          cur_g1v, cur_g2v;
  int unsigned cur_g1, cur_g2;
  logic [NREQ-1:0] exp_fc [4];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned op_a(input int unsigned i);
    return int'(req_a[10*i +: 10]);
  endfunction

  function automatic int unsigned op_b(input int unsigned i);
    return int'(req_b[9*i +: 9]);
  endfunction

  task automatic new_ops(input int unsigned i);
    req_a[10*i +: 10] = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
    req_b[9*i +: 9]   = ($urandom_range(0, 7) == 0) ? 9'd511 : 9'($urandom_range(0, 511));
  endtask

  task automatic model_grant();
    cur_g1v = 1'b0;
    cur_g2v = 1'b0;
    cur_g1  = 0;
    cur_g2  = 0;
    if (!rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        int unsigned i;
        i = (m_ptr + k) % NREQ;
        if (req_valid[i]) begin
          if (!cur_g1v) begin
            cur_g1v = 1'b1;
            cur_g1  = i;
          end else if (!cur_g2v) begin
            cur_g2v = 1'b1;
            cur_g2  = i;
          end
        end
      end
    end
  endtask

  // Check one cycle against the model, then advance across the clock edge.
  task automatic cycle();
    logic [NREQ-1:0] er;
    int unsigned ea1, eb1, ea2, eb2;
    tag_t t1, t2;
    model_grant();
    er = '0;
    if (cur_g1v) er[cur_g1] = 1'b1;
    if (cur_g2v) er[cur_g2] = 1'b1;
    ea1 = cur_g1v ? op_a(cur_g1) : 0;
    eb1 = cur_g1v ? op_b(cur_g1) : 0;
    ea2 = cur_g2v ? op_a(cur_g2) : 0;
    eb2 = cur_g2v ? op_b(cur_g2) : 0;
    #1;
    for (int l = 0; l < NLAT; l++) begin
      check($sformatf("L%0d req_ready", l), obs_ready[l], er);
      check($sformatf("L%0d dsp_a1", l), obs_a1[l], ea1);
      check($sformatf("L%0d dsp_b1", l), obs_b1[l], eb1);
      check($sformatf("L%0d dsp_a2", l), obs_a2[l], ea2);
      check($sformatf("L%0d dsp_b2", l), obs_b2[l], eb2);
      check($sformatf("L%0d rsp1_valid", l), obs_r1v[l], pipe1[l][l].v);
      check($sformatf("L%0d rsp1_id", l), obs_r1id[l], hold1[l].id);
      check($sformatf("L%0d rsp1_z", l), obs_r1z[l], hold1[l].z);
      check($sformatf("L%0d rsp2_valid", l), obs_r2v[l], pipe2[l][l].v);
      check($sformatf("L%0d rsp2_id", l), obs_r2id[l], hold2[l].id);
      check($sformatf("L%0d rsp2_z", l), obs_r2z[l], hold2[l].z);
    end
    @(posedge clk);
    t1.v  = cur_g1v;
    t1.id = IDW'(cur_g1);
    t1.z  = 19'(ea1 * eb1);
    t2.v  = cur_g2v;
    t2.id = IDW'(cur_g2);
    t2.z  = 19'(ea2 * eb2);
    for (int l = 0; l < NLAT; l++) begin
      if (rst) begin
        for (int k = 0; k < NLAT; k++) begin
          pipe1[l][k] = '0;
          pipe2[l][k] = '0;
        end
        hold1[l] = '0;
        hold2[l] = '0;
      end else begin
        for (int k = NLAT - 1; k > 0; k--) begin
          pipe1[l][k] = pipe1[l][k-1];
          pipe2[l][k] = pipe2[l][k-1];
        end
        pipe1[l][0] = t1;
        pipe2[l][0] = t2;
        if (pipe1[l][l].v) hold1[l] = pipe1[l][l];
        if (pipe2[l][l].v) hold2[l] = pipe2[l][l];
      end
    end
    if (rst) m_ptr = 0;
    else if (cur_g1v) m_ptr = ((cur_g2v ? cur_g2 : cur_g1) + 1) % NREQ;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int l = 0; l < NLAT; l++) begin
      hold1[l] = '0;
      hold2[l] = '0;
      for (int k = 0; k < NLAT; k++) begin
        pipe1[l][k] = '0;
        pipe2[l][k] = '0;
      end
    end
    exp_fc[0] = 4'b0011;
    exp_fc[1] = 4'b1100;
    exp_fc[2] = 4'b0011;
    exp_fc[3] = 4'b1100;

    // Reset: ready forced low even with every request valid.
    rst = 1'b1;
    @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check("ready held low in reset", obs_ready[0], 0);
    cycle();
    req_valid = '0;
    cycle();
    rst = 1'b0;
    check("reset rsp1_valid", obs_r1v[2], 0);
    check("reset rsp2_z", obs_r2z[1], 0);

    // Idle.
    cycle();
    cycle();
    check("idle dsp_a1", obs_a1[0], 0);
    check("idle dsp_b2", obs_b2[2], 0);
    check("idle rsp1_valid", obs_r1v[0], 0);

    // Single op from requester 2 at max operands.
    req_valid        = 4'b0100;
    req_a[29:20]     = 10'd1023;
    req_b[26:18]     = 9'd511;
    #1;
    check("single ready", obs_ready[0], 4'b0100);
    check("single dsp_a1", obs_a1[0], 1023);
    check("single dsp_b1", obs_b1[0], 511);
    check("single dsp_a2", obs_a2[0], 0);
    cycle();
    req_valid = '0;
    check("single L0 rsp1_valid", obs_r1v[0], 1);
    check("single L0 rsp1_id", obs_r1id[0], 2);
    check("single L0 rsp1_z", obs_r1z[0], 522753);
    check("single L0 rsp2_valid", obs_r2v[0], 0);
    check("single L1 early", obs_r1v[1], 0);
    cycle();
    check("single L1 rsp1_z", obs_r1z[1], 522753);
    check("single L0 valid drops", obs_r1v[0], 0);
    check("single L0 z holds", obs_r1z[0], 522753);
    cycle();
    check("single L2 rsp1_valid", obs_r1v[2], 1);
    check("single L2 rsp1_id", obs_r1id[2], 2);

    // Wrap from ptr=3: lane 1 = id 3, lane 2 = id 0.
    req_valid    = 4'b1001;
    req_a[39:30] = 10'd5;
    req_b[35:27] = 9'd7;
    req_a[9:0]   = 10'd100;
    req_b[8:0]   = 9'd3;
    #1;
    check("wrap ready", obs_ready[0], 4'b1001);
    check("wrap dsp_a1", obs_a1[1], 5);
    check("wrap dsp_a2", obs_a2[1], 100);
    cycle();
    req_valid = '0;
    check("wrap rsp1_id", obs_r1id[0], 3);
    check("wrap rsp1_z", obs_r1z[0], 35);
    check("wrap rsp2_valid", obs_r2v[0], 1);
    check("wrap rsp2_id", obs_r2id[0], 0);
    check("wrap rsp2_z", obs_r2z[0], 300);
    // ptr is now 1; a lone request from 3 brings it back to 0.
    req_valid = 4'b1000;
    #1;
    check("ptr after wrap", obs_ready[0], 4'b1000);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    cycle();

    // Full contention, back-to-back for four cycles.
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_a[10*i +: 10] = 10'(i * 100 + 1);
      req_b[9*i +: 9]   = 9'(i * 50 + 2);
    end
    req_valid = '1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("contention ready c%0d", c), obs_ready[0], exp_fc[c]);
      cycle();
    end
    #1;
    check("contention ptr back to 0", obs_ready[2], 4'b0011);
    req_valid = '0;
    cycle();
    cycle();
    cycle();
    cycle();

    // Reset one cycle after granting two ops.
    req_valid = 4'b0011;
    cycle();
    req_valid = '0;
    rst       = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("flush L2 rsp1_valid c%0d", c), obs_r1v[2], 0);
      check($sformatf("flush L2 rsp2_valid c%0d", c), obs_r2v[2], 0);
      check($sformatf("flush L2 rsp1_z c%0d", c), obs_r1z[2], 0);
      check($sformatf("flush L1 rsp2_id c%0d", c), obs_r2id[1], 0);
      cycle();
    end
    req_valid = 4'b0010;
    #1;
    check("resume ready", obs_ready[2], 4'b0010);
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    check("resume L2 rsp1_valid", obs_r1v[2], 1);
    check("resume L2 rsp1_id", obs_r1id[2], 1);

    // Random stream; requesters hold operands until granted.
    req_valid = '0;
    for (int c = 0; c < 700; c++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          new_ops(i);
        end
      end
      rst = ($urandom_range(0, 249) == 0);
      cycle();
      rst = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if ((cur_g1v && cur_g1 == i) || (cur_g2v && cur_g2 == i)) begin
          if ($urandom_range(0, 1) != 0) new_ops(i);
          else req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
